// File: rtl/aig_bist_pkg.sv
// Purpose: shared definitions for the AIG BIST response path.
//   - state_e     : response compactor FSM states
//   - DEF_POLY    : default MISR feedback taps (x^8+x^4+x^3+x^2+1, MSB implied)
//   - DEF_SEED    : default MISR seed
//   - misr_next() : one MISR step on an 8-bit signature, reused by the
//                   upstream pattern generator for golden-signature computation
package aig_bist_pkg;

    localparam int          MISR_W   = 8;
    localparam logic [7:0]  DEF_POLY = 8'h1D;
    localparam logic [7:0]  DEF_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift left, fold the outgoing MSB back through the taps, then mix in data.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] data,
        input logic [MISR_W-1:0] poly
    );
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? poly : {MISR_W{1'b0}};
        return ({sig[MISR_W-2:0], 1'b0} ^ fb) ^ data;
    endfunction

endpackage

// File: rtl/misr_step.sv
// Purpose: combinational single-step MISR update.
// Ports:
//   i_sig  [OUT_W] : current signature
//   i_data [OUT_W] : response vector folded in this step
//   o_sig  [OUT_W] : next signature
module misr_step #(
    parameter int               OUT_W = 8,
    parameter logic [OUT_W-1:0] POLY  = 8'h1D
) (
    input  logic [OUT_W-1:0] i_sig,
    input  logic [OUT_W-1:0] i_data,
    output logic [OUT_W-1:0] o_sig
);

    logic [OUT_W-1:0] w_fb;

    // Feedback taps applied only when the bit shifted out is set.
    always_comb begin
        if (i_sig[OUT_W-1]) begin
            w_fb = POLY;
        end else begin
            w_fb = {OUT_W{1'b0}};
        end
        o_sig = ({i_sig[OUT_W-2:0], 1'b0} ^ w_fb) ^ i_data;
    end

endmodule

// File: rtl/aig_response_misr.sv
// Purpose: compacts a programmed number of response vectors into a MISR
//          signature and compares it with an expected value.
// Ports:
//   clk, rst_n (sync, active-low)
//   start, num_vec[CNT_W], exp_sig[OUT_W] : run request and its parameters
//   in_valid, in_data[OUT_W], in_ready    : response vector handshake
//   busy, done, pass                      : run status (pass valid with done)
//   signature[OUT_W], vec_count[CNT_W]    : live MISR contents and count
module aig_response_misr
    import aig_bist_pkg::*;
#(
    parameter int               OUT_W = 8,
    parameter int               CNT_W = 16,
    parameter logic [OUT_W-1:0] POLY  = DEF_POLY,
    parameter logic [OUT_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [OUT_W-1:0] exp_sig,
    input  logic             in_valid,
    input  logic [OUT_W-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    state_e           r_state;
    state_e           w_next_state;
    logic [OUT_W-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num_vec;
    logic [OUT_W-1:0] r_exp_sig;

    logic             w_accept_start;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [OUT_W-1:0] w_sig_next;

    misr_step #(
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr_step (
        .i_sig  (r_sig),
        .i_data (in_data),
        .o_sig  (w_sig_next)
    );

    assign w_accept_start = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_xfer         = in_valid && (r_state == RUN);
    // num_vec never exceeds 2^CNT_W-1, so the increment cannot wrap before
    // it matches and ends the run.
    assign w_cnt_inc      = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state logic; a start from DONE behaves exactly like one from IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    if (num_vec == {CNT_W{1'b0}}) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = RUN;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            RUN: begin
                if (w_xfer && (w_cnt_inc == r_num_vec)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Signature, counter and latched run parameters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig     <= SEED;
            r_cnt     <= {CNT_W{1'b0}};
            r_num_vec <= {CNT_W{1'b0}};
            r_exp_sig <= {OUT_W{1'b0}};
        end else if (w_accept_start) begin
            r_sig     <= SEED;
            r_cnt     <= {CNT_W{1'b0}};
            r_num_vec <= num_vec;
            r_exp_sig <= exp_sig;
        end else if (w_xfer) begin
            r_sig     <= w_sig_next;
            r_cnt     <= w_cnt_inc;
        end else begin
            r_sig     <= r_sig;
            r_cnt     <= r_cnt;
        end
    end

    assign in_ready  = (r_state == RUN);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (r_sig == r_exp_sig);
    assign signature = r_sig;
    assign vec_count = r_cnt;

endmodule

// File: tb/tb_aig_response_misr.sv
// Purpose: directed self-checking bench for aig_response_misr. Inputs are
// driven 1 time unit after the rising edge and outputs sampled there too.
module tb_aig_response_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic [7:0]  exp_sig;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [15:0] vec_count;

    int n_checks;
    int n_errors;

    aig_response_misr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .exp_sig   (exp_sig),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n, input logic [7:0] e);
        start   = 1'b1;
        num_vec = n;
        exp_sig = e;
        step();
        start   = 1'b0;
        num_vec = 16'h0;
        exp_sig = 8'h00;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic chk_final(input string tag, input logic [7:0] s, input logic [15:0] c, input logic p);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".sig"},  {24'd0, signature}, {24'd0, s});
        chk({tag, ".cnt"},  {16'd0, vec_count}, {16'd0, c});
        chk({tag, ".pass"}, {31'd0, pass}, {31'd0, p});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"},  {31'd0, in_ready}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
        chk({tag, ".pass"}, {31'd0, pass}, 32'd0);
        chk({tag, ".sig"},  {24'd0, signature}, 32'h00);
        chk({tag, ".cnt"},  {16'd0, vec_count}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        num_vec  = 16'h0;
        exp_sig  = 8'h00;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        rst_n = 1'b1;

        // Reset and idle: data offered without start is ignored.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            chk_reset("idle");
            step();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Two-vector run: A5 -> A5, 3C -> 6B.
        start_run(16'd2, 8'h6B);
        chk("run1.busy", {31'd0, busy}, 32'd1);
        chk("run1.rdy",  {31'd0, in_ready}, 32'd1);
        chk("run1.done", {31'd0, done}, 32'd0);
        send(8'hA5);
        chk("run1.sig1", {24'd0, signature}, 32'hA5);
        chk("run1.cnt1", {16'd0, vec_count}, 32'd1);
        send(8'h3C);
        chk_final("run1", 8'h6B, 16'd2, 1'b1);
        step();
        chk_final("run1.hold", 8'h6B, 16'd2, 1'b1);

        // Feedback: 80 then 00 -> 1D, does not match 00.
        start_run(16'd2, 8'h00);
        chk("fb.busy", {31'd0, busy}, 32'd1);
        chk("fb.sig0", {24'd0, signature}, 32'h00);
        send(8'h80);
        chk("fb.sig1", {24'd0, signature}, 32'h80);
        send(8'h00);
        chk_final("fb", 8'h1D, 16'd2, 1'b0);

        // Backpressure with a start pulse mid-run.
        start_run(16'd2, 8'h6B);
        send(8'hA5);
        in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            start   = (i == 1);
            num_vec = 16'd0;
            exp_sig = 8'h00;
            step();
            chk("bp.sig",  {24'd0, signature}, 32'hA5);
            chk("bp.cnt",  {16'd0, vec_count}, 32'd1);
            chk("bp.busy", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        send(8'h3C);
        chk_final("bp", 8'h6B, 16'd2, 1'b1);

        // Zero-length run, then restart from DONE with one vector.
        start_run(16'd0, 8'h00);
        chk_final("zero", 8'h00, 16'd0, 1'b1);
        start_run(16'd1, 8'h5A);
        chk("rs.busy", {31'd0, busy}, 32'd1);
        chk("rs.done", {31'd0, done}, 32'd0);
        send(8'h5A);
        chk_final("rs", 8'h5A, 16'd1, 1'b1);

        // Mid-run reset, then a normal run.
        start_run(16'd2, 8'h6B);
        send(8'hA5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset("mrst");
        start_run(16'd2, 8'h6B);
        send(8'hA5);
        send(8'h3C);
        chk_final("post", 8'h6B, 16'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
